javk_bus_unit: RTL and testbench



---
 rtl/javk_bus_unit.sv | 84 ++++++++
 tb/tb_javk_bus_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/javk_bus_unit.sv
// javk_bus_unit: single-request external bus interface with wait states, bus_ready, timeout and write turnaround.
module javk_bus_unit #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 0,
  parameter int TURN_CYCLES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  input  logic              bus_ready,
  inout  wire  [DATA_W-1:0] databus,
  output logic [ADDR_W-1:0] addrbus,
  output logic              rw
);
  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam logic [7:0] TO = 8'(TIMEOUT);
  localparam logic [1:0] TL = 2'(TURN_CYCLES - 1);
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              rw_q, rv_q, err_q;
  logic [3:0]        wait_q;
  logic [7:0]        tmo_q;
  logic [1:0]        turn_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rw_q    <= 1'b0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      tmo_q   <= '0;
      turn_q  <= '0;
    end else begin
      rv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          rw_q    <= req_write;
          wait_q  <= '0;
          tmo_q   <= '0;
          state_q <= ACCESS;
        end
        ACCESS: if (wait_q != WS) begin
          wait_q <= wait_q + 4'd1;
        end else if (bus_ready || tmo_q == TO) begin
          // bus_ready wins over an expiring timeout in the same cycle
          rv_q    <= 1'b1;
          err_q   <= !bus_ready;
          if (bus_ready && !rw_q) rdata_q <= databus;
          rw_q    <= 1'b0;
          turn_q  <= '0;
          state_q <= (rw_q && TURN_CYCLES > 0) ? TURN : IDLE;
        end else begin
          tmo_q <= tmo_q + 8'd1;
        end
        TURN: if (turn_q == TL) state_q <= IDLE; else turn_q <= turn_q + 2'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign databus    = rw_q ? wdata_q : 'z;
  assign req_ready  = state_q == IDLE;
  assign resp_valid = rv_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign addrbus    = addr_q;
  assign rw         = rw_q;
endmodule

// File: tb/tb_javk_bus_unit.sv
// tb_javk_bus_unit: directed checks on a zero-wait unit (u0) and a two-wait, two-turn unit (u1).
module tb_javk_bus_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rv0 = 1'b0, rv1 = 1'b0, wr = 1'b0, br = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  wd = '0;
  logic        dev_en0 = 1'b0, dev_en1 = 1'b0;
  logic [7:0]  dev_d0 = '0, dev_d1 = '0;
  logic        rdy0, rdy1, vld0, vld1, err0, err1, rw0, rw1;
  logic [7:0]  rd0, rd1;
  logic [15:0] ab0, ab1;
  wire  [7:0]  db0, db1;
  int          total = 0, bad = 0;

  assign db0 = dev_en0 ? dev_d0 : 'z;
  assign db1 = dev_en1 ? dev_d1 : 'z;

  javk_bus_unit #(.WAIT_STATES(0), .TURN_CYCLES(1), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rdy0), .req_write(wr),
    .req_addr(addr), .req_wdata(wd), .resp_valid(vld0), .resp_rdata(rd0),
    .resp_err(err0), .bus_ready(br), .databus(db0), .addrbus(ab0), .rw(rw0));
  javk_bus_unit #(.WAIT_STATES(2), .TURN_CYCLES(2), .TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1), .req_write(wr),
    .req_addr(addr), .req_wdata(wd), .resp_valid(vld1), .resp_rdata(rd1),
    .resp_err(err1), .bus_ready(br), .databus(db1), .addrbus(ab1), .rw(rw1));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset; device probes both buses to prove they are released
    dev_en0 = 1; dev_d0 = 8'h11; dev_en1 = 1; dev_d1 = 8'h22;
    step(); step();
    chk("rst_ready0", rdy0, 1); chk("rst_ready1", rdy1, 1);
    chk("rst_rw0", rw0, 0);     chk("rst_addr0", ab0, 0);
    chk("rst_vld0", vld0, 0);   chk("rst_err0", err0, 0);
    chk("rst_rdata0", rd0, 0);  chk("rst_db0", db0, 8'h11);
    chk("rst_db1", db1, 8'h22);
    rst = 0; dev_en1 = 0;

    // read, zero waits, device drives A5
    wr = 0; addr = 16'h1234; dev_d0 = 8'hA5; br = 1; rv0 = 1;
    step(); rv0 = 0;
    chk("rd_addr", ab0, 16'h1234); chk("rd_rw", rw0, 0); chk("rd_busy", rdy0, 0);
    chk("rd_vld_early", vld0, 0);
    step();
    chk("rd_vld", vld0, 1); chk("rd_data", rd0, 8'hA5); chk("rd_err", err0, 0);
    chk("rd_ready_back", rdy0, 1);
    step();
    chk("rd_vld_pulse", vld0, 0);

    // read, bus_ready low four cycles beyond the waits
    addr = 16'h0042; dev_d0 = 8'h5A; rv0 = 1;
    step(); rv0 = 0; br = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("slow_vld_low", vld0, 0);
    end
    br = 1;
    step();
    chk("slow_vld", vld0, 1); chk("slow_data", rd0, 8'h5A); chk("slow_err", err0, 0);
    step();

    // read, bus_ready stuck low: abort at edge 1+0+8, rdata kept
    addr = 16'h0043; dev_d0 = 8'h77; br = 0; rv0 = 1;
    step(); rv0 = 0;
    for (int i = 0; i < 8; i++) step();
    chk("to_vld_early", vld0, 0);
    step();
    chk("to_vld", vld0, 1); chk("to_err", err0, 1); chk("to_rdata_kept", rd0, 8'h5A);
    chk("to_rw", rw0, 0);
    br = 1;
    step();
    chk("to_vld_pulse", vld0, 0); chk("to_err_clear", err0, 0);
    dev_en0 = 0;

    // write 3C to 00FF with a read queued behind it on u1
    wr = 1; addr = 16'h00FF; wd = 8'h3C; rv1 = 1;
    step();
    wr = 0; addr = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      chk("wr_rw", rw1, 1); chk("wr_db", db1, 8'h3C); chk("wr_addr", ab1, 16'h00FF);
      chk("wr_vld_low", vld1, 0);
      if (i < 2) step();
    end
    dev_en1 = 1; dev_d1 = 8'hE1;
    step();
    chk("wr_vld", vld1, 1); chk("wr_err", err1, 0); chk("wr_rw_off", rw1, 0);
    chk("turn1_db", db1, 8'hE1); chk("turn1_busy", rdy1, 0);
    step();
    chk("turn2_vld", vld1, 0); chk("turn2_rw", rw1, 0);
    chk("turn2_db", db1, 8'hE1); chk("turn2_busy", rdy1, 0);
    step();
    chk("idle_ready", rdy1, 1); chk("idle_db", db1, 8'hE1); chk("idle_addr", ab1, 16'h00FF);
    step(); rv1 = 0; dev_d1 = 8'hC3;
    chk("b2b_addr", ab1, 16'h0100); chk("b2b_rw", rw1, 0); chk("b2b_busy", rdy1, 0);
    step();
    chk("b2b_vld_early", vld1, 0);
    step();
    chk("b2b_vld_early2", vld1, 0);
    step();
    chk("b2b_vld", vld1, 1); chk("b2b_data", rd1, 8'hC3); chk("b2b_err", err1, 0);
    step();
    dev_en1 = 0;

    // reset in the second access cycle of a write
    wr = 1; addr = 16'hBEEF; wd = 8'h99; rv1 = 1;
    step(); rv1 = 0;
    chk("rw_mid_rw", rw1, 1);
    step();
    rst = 1;
    step();
    dev_en1 = 1; dev_d1 = 8'h66;
    #1;
    chk("mid_rst_rw", rw1, 0); chk("mid_rst_db", db1, 8'h66);
    chk("mid_rst_addr", ab1, 0); chk("mid_rst_vld", vld1, 0); chk("mid_rst_ready", rdy1, 1);
    rst = 0; dev_en1 = 0;
    step();
    chk("post_rst_vld", vld1, 0); chk("post_rst_rw", rw1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
